// File: rtl/game_engine_axil_slave_regs.sv
// AXI4-Lite register file for the game engine peripheral: NUM_REGS 32-bit control registers,
// one outstanding write and one outstanding read, SLVERR outside the register window.
module game_engine_axil_slave_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] regs_out,
    output logic                                   reg_wr_pulse,
    output logic [3:0]                             reg_wr_index
);

    localparam int unsigned IdxW  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [2:0] {WIdle, WHaveA, WHaveD, WCommit, WResp} wstate_e;
    typedef enum logic {RIdle, RResp} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic [IdxW-1:0]               aw_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [StrbW-1:0]              wstrb_q;
    logic                          awready_q, awready_d;
    logic                          wready_q, wready_d;
    logic [1:0]                    bresp_q;
    logic                          reg_wr_pulse_q;
    logic [3:0]                    reg_wr_index_q;

    logic                          arready_q, arready_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                    rresp_q;

    logic                          aw_hs, w_hs, ar_hs;
    logic                          aw_in_range, ar_in_range;
    logic [IdxW-1:0]               ar_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_val;

    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign aw_hs       = s00_axi_awvalid & awready_q;
    assign w_hs        = s00_axi_wvalid & wready_q;
    assign ar_hs       = s00_axi_arvalid & arready_q;
    assign ar_idx      = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign aw_in_range = 32'(aw_idx_q) < NUM_REGS;
    assign ar_in_range = 32'(ar_idx) < NUM_REGS;

    // ---------------- write channel ----------------
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            WIdle: begin
                if (aw_hs && w_hs) wstate_d = WCommit;
                else if (aw_hs)    wstate_d = WHaveA;
                else if (w_hs)     wstate_d = WHaveD;
            end
            WHaveA:  if (w_hs) wstate_d = WCommit;
            WHaveD:  if (aw_hs) wstate_d = WCommit;
            WCommit: wstate_d = WResp;
            WResp:   if (s00_axi_bready) wstate_d = WIdle;
            default: wstate_d = WIdle;
        endcase
        // Ready flags are registered from the next state so they never follow an input combinationally.
        awready_d = (wstate_d == WIdle) || (wstate_d == WHaveD);
        wready_d  = (wstate_d == WIdle) || (wstate_d == WHaveA);
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wstate_q       <= WIdle;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            aw_idx_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            bresp_q        <= RespOkay;
            reg_wr_pulse_q <= 1'b0;
            reg_wr_index_q <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            wstate_q       <= wstate_d;
            awready_q      <= awready_d;
            wready_q       <= wready_d;
            reg_wr_pulse_q <= 1'b0;
            if (aw_hs) aw_idx_q <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
            if (wstate_q == WCommit) begin
                bresp_q <= aw_in_range ? RespOkay : RespSlverr;
                if (aw_in_range && (|wstrb_q)) begin
                    reg_wr_pulse_q <= 1'b1;
                    reg_wr_index_q <= 4'(aw_idx_q);
                end
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    for (int unsigned b = 0; b < StrbW; b++) begin
                        if (aw_in_range && (32'(aw_idx_q) == k) && wstrb_q[b]) begin
                            regs_q[k][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // ---------------- read channel ----------------
    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(ar_idx) == k) rd_val = regs_q[k];
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            RIdle:   if (ar_hs) rstate_d = RResp;
            RResp:   if (s00_axi_rready) rstate_d = RIdle;
            default: rstate_d = RIdle;
        endcase
        arready_d = (rstate_d == RIdle);
    end

    // rd_val samples regs_q before this edge's commit, so a colliding read sees the old value.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rstate_q  <= RIdle;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= ar_in_range ? RespOkay : RespSlverr;
            end
        end
    end

    // ---------------- outputs ----------------
    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = (wstate_q == WResp);
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = (rstate_q == RResp);
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign reg_wr_pulse    = reg_wr_pulse_q;
    assign reg_wr_index    = reg_wr_index_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[C_S_AXI_DATA_WIDTH*k +: C_S_AXI_DATA_WIDTH] = regs_q[k];
    end

endmodule

// File: tb/tb_game_engine_axil_slave_regs.sv
// Scoreboard bench for game_engine_axil_slave_regs: directed AXI-Lite traffic, expected B/R/pulse
// responses queued by the stimulus and checked by independent monitors.
module tb_game_engine_axil_slave_regs;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [5:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b1;
    logic [5:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b1;
    logic [127:0] regs_out;
    logic         reg_wr_pulse;
    logic [3:0]   reg_wr_index;

    always #5 clk = ~clk;

    game_engine_axil_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .NUM_REGS          (4)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .regs_out       (regs_out),
        .reg_wr_pulse   (reg_wr_pulse),
        .reg_wr_index   (reg_wr_index)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          checks = 0;
    int          failures = 0;
    logic [1:0]  b_q[$];
    rexp_t       r_q[$];
    logic [3:0]  p_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors sample 1 time unit after the falling edge, once the bench has settled its inputs.
    always begin
        @(negedge clk);
        #1;
        if (aresetn) begin
            if (bvalid && bready) begin
                if (b_q.size() == 0) chk("b_unexpected", 64'(bvalid), 64'd0);
                else chk("bresp", 64'(bresp), 64'(b_q.pop_front()));
            end
            if (rvalid && rready) begin
                if (r_q.size() == 0) chk("r_unexpected", 64'(rvalid), 64'd0);
                else begin
                    rexp_t e;
                    e = r_q.pop_front();
                    chk("rdata", 64'(rdata), 64'(e.data));
                    chk("rresp", 64'(rresp), 64'(e.resp));
                end
            end
            if (reg_wr_pulse) begin
                if (p_q.size() == 0) chk("pulse_unexpected", 64'(reg_wr_pulse), 64'd0);
                else chk("wr_index", 64'(reg_wr_index), 64'(p_q.pop_front()));
            end
        end
    end

    task automatic do_aw(input logic [5:0] a);
        awaddr  = a;
        awvalid = 1'b1;
        for (int n = 0; n < 100 && !awready; n++) @(negedge clk);
        if (!awready) chk("aw_timeout", 64'(awready), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int n = 0; n < 100 && !wready; n++) @(negedge clk);
        if (!wready) chk("w_timeout", 64'(wready), 64'd1);
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [5:0] a);
        araddr  = a;
        arvalid = 1'b1;
        for (int n = 0; n < 100 && !arready; n++) @(negedge clk);
        if (!arready) chk("ar_timeout", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic wait_b();
        for (int n = 0; n < 100 && !(bvalid && bready); n++) @(negedge clk);
        if (!bvalid) chk("b_timeout", 64'(bvalid), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_r();
        for (int n = 0; n < 100 && !(rvalid && rready); n++) @(negedge clk);
        if (!rvalid) chk("r_timeout", 64'(rvalid), 64'd1);
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp, input logic pulse);
        b_q.push_back(resp);
        if (pulse) p_q.push_back(a[5:2]);
        fork
            do_aw(a);
            do_w(d, s);
        join
        wait_b();
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp);
        rexp_t e;
        e.data = d;
        e.resp = resp;
        r_q.push_back(e);
        do_ar(a);
        wait_r();
    endtask

    task automatic chk_regs(input string name, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
        chk({name, "_r0"}, 64'(regs_out[31:0]),   64'(r0));
        chk({name, "_r1"}, 64'(regs_out[63:32]),  64'(r1));
        chk({name, "_r2"}, 64'(regs_out[95:64]),  64'(r2));
        chk({name, "_r3"}, 64'(regs_out[127:96]), 64'(r3));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 64'({awready, wready, bvalid, arready, rvalid, reg_wr_pulse}), 64'd0);
        chk("rst_data", 64'({bresp, rresp, rdata, reg_wr_index}), 64'd0);
        chk_regs("rst", 32'h0, 32'h0, 32'h0, 32'h0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'({awready, wready, arready}), 64'h7);

        // ---- sequential write / read ----
        axi_write(6'h00, 32'h0101FFFF, 4'hF, 2'b00, 1'b1);
        axi_write(6'h04, 32'habcd0001, 4'hF, 2'b00, 1'b1);
        axi_write(6'h08, 32'hdead0011, 4'hF, 2'b00, 1'b1);
        axi_write(6'h0C, 32'hbeef0011, 4'hF, 2'b00, 1'b1);
        chk_regs("seq", 32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011);
        axi_read(6'h00, 32'h0101FFFF, 2'b00);
        axi_read(6'h04, 32'habcd0001, 2'b00);
        axi_read(6'h08, 32'hdead0011, 2'b00);
        axi_read(6'h0C, 32'hbeef0011, 2'b00);

        // ---- W before AW ----
        b_q.push_back(2'b00);
        p_q.push_back(4'd1);
        do_w(32'h12345678, 4'hF);
        repeat (2) @(negedge clk);
        do_aw(6'h04);
        chk("w_first_bvalid_early", 64'(bvalid), 64'd0);
        @(negedge clk);
        chk("w_first_bvalid", 64'(bvalid), 64'd1);
        @(negedge clk);

        // ---- AW before W ----
        b_q.push_back(2'b00);
        p_q.push_back(4'd2);
        do_aw(6'h08);
        repeat (2) @(negedge clk);
        do_w(32'hCAFEBABE, 4'hF);
        chk("aw_first_bvalid_early", 64'(bvalid), 64'd0);
        @(negedge clk);
        chk("aw_first_bvalid", 64'(bvalid), 64'd1);
        @(negedge clk);
        axi_read(6'h04, 32'h12345678, 2'b00);
        axi_read(6'h08, 32'hCAFEBABE, 2'b00);

        // ---- byte strobes ----
        axi_write(6'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 1'b1);
        axi_write(6'h00, 32'h00AA00BB, 4'b0101, 2'b00, 1'b1);
        axi_read(6'h00, 32'hFFAAFFBB, 2'b00);
        axi_write(6'h00, 32'h12345678, 4'b0000, 2'b00, 1'b0);
        axi_read(6'h00, 32'hFFAAFFBB, 2'b00);

        // ---- out of range with backpressure ----
        bready = 1'b0;
        rready = 1'b0;
        b_q.push_back(2'b10);
        begin
            rexp_t e;
            e.data = 32'h0;
            e.resp = 2'b10;
            r_q.push_back(e);
        end
        fork
            do_aw(6'h10);
            do_w(32'h55AA55AA, 4'hF);
            do_ar(6'h10);
        join
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("oor_hold", 64'({bvalid, bresp, rvalid, rresp, awready, wready, arready}),
                64'({1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0}));
            chk("oor_rdata", 64'(rdata), 64'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        chk("oor_ready_back", 64'({awready, wready, arready, bvalid, rvalid}), 64'h1C);
        chk_regs("oor", 32'hFFAAFFBB, 32'h12345678, 32'hCAFEBABE, 32'hbeef0011);

        // ---- read/write collision ----
        axi_write(6'h04, 32'h11111111, 4'hF, 2'b00, 1'b1);
        b_q.push_back(2'b00);
        p_q.push_back(4'd1);
        begin
            rexp_t e;
            e.data = 32'h11111111;
            e.resp = 2'b00;
            r_q.push_back(e);
        end
        chk("col_ready", 64'({awready, wready, arready}), 64'h7);
        awaddr  = 6'h04;
        wdata   = 32'h22222222;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = 6'h04;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("col_both_valid", 64'({bvalid, rvalid}), 64'h3);
        repeat (2) @(negedge clk);
        axi_read(6'h04, 32'h22222222, 2'b00);

        // ---- reset mid-operation ----
        bready = 1'b0;
        rready = 1'b0;
        b_q.push_back(2'b00);
        p_q.push_back(4'd0);
        fork
            do_aw(6'h00);
            do_w(32'hA5A5A5A5, 4'hF);
        join
        @(negedge clk);
        chk("pre_rst_bvalid", 64'(bvalid), 64'd1);
        araddr  = 6'h08;
        arvalid = 1'b1;
        @(negedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_ctrl", 64'({awready, wready, bvalid, arready, rvalid, reg_wr_pulse}), 64'd0);
        chk("mid_rst_data", 64'({bresp, rresp, rdata, reg_wr_index}), 64'd0);
        chk_regs("mid_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        b_q.delete();
        r_q.delete();
        arvalid = 1'b0;
        bready  = 1'b1;
        rready  = 1'b1;
        @(negedge clk);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        axi_read(6'h00, 32'h0, 2'b00);
        axi_read(6'h04, 32'h0, 2'b00);
        axi_read(6'h08, 32'h0, 2'b00);
        axi_read(6'h0C, 32'h0, 2'b00);
        axi_write(6'h0C, 32'h0BADF00D, 4'hF, 2'b00, 1'b1);
        axi_read(6'h0C, 32'h0BADF00D, 2'b00);

        repeat (3) @(negedge clk);
        chk("sb_b_drain", 64'(b_q.size()), 64'd0);
        chk("sb_r_drain", 64'(r_q.size()), 64'd0);
        chk("sb_p_drain", 64'(p_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_engine_axil_slave_regs.md
Name: game_engine_axil_slave_regs

Overview:
AXI4-Lite responder (slave) register file for the game engine peripheral. It terminates the S00_AXI interface that the bench and the PS master drive. It holds NUM_REGS 32-bit control registers and presents them to game logic, with a one-cycle update strobe. It accepts write address and write data in either order, holds at most one outstanding write and one outstanding read, and returns SLVERR for offsets outside the register window.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width.
NUM_REGS, 4, number of implemented registers at byte offsets 0x0, 0x4, 0x8 and so on; allowed range 1..16.

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte-lane enables
s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake
s00_axi_bresp  out  2  write response
s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake
regs_out  out  32*NUM_REGS  register contents; reg k occupies bits [32k+31:32k]
reg_wr_pulse  out  1  one-cycle strobe on every committed in-range write
reg_wr_index  out  4  index of the register written; valid while reg_wr_pulse=1

Behaviour:
- Reset: asynchronous assert, synchronous deassert on s00_axi_aclk. While aresetn=0:
  - all registers read 0;
  - awready, wready, bvalid, arready, rvalid and reg_wr_pulse are 0;
  - bresp, rresp, rdata and reg_wr_index are 0;
  - any held AW/W/AR is discarded, and any in-flight B or R is dropped.
- Index: bits [C_S_AXI_ADDR_WIDTH-1:2] of the address. Bits [1:0] are ignored. An index >= NUM_REGS is out of range.
- Write channel (states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP):
  - awready=1 when no AW is held and bvalid=0. wready=1 when no W is held and bvalid=0. Both are registered outputs.
  - An AW handshake (awvalid & awready) latches the address. A W handshake latches data and strobes. The two may occur in the same cycle or in either order.
  - In the cycle both are held, the write commits on the next edge. Each byte lane i with wstrb[i]=1 updates; other lanes keep their value. Strobes of 0000 commit nothing but still respond OKAY.
  - On the commit edge: bvalid goes to 1; bresp is 2'b00 if in range, otherwise 2'b10 with no register change; reg_wr_pulse=1 for exactly one cycle (in range only) with reg_wr_index set.
  - Latency: minimum 2 cycles from a concurrent AW+W handshake to bvalid.
  - bvalid and bresp hold until bready. After the B handshake, awready and wready return to 1 on the next edge.
- Read channel (states R_IDLE, R_RESP):
  - arready=1 when rvalid=0.
  - On the AR handshake edge, rdata is loaded from the register file and rvalid goes to 1. This is a 1-cycle latency.
  - Out-of-range reads return rdata=0 and rresp=2'b10.
  - rdata and rresp hold until rready. arready returns to 1 the edge after the R handshake; back-to-back reads therefore take 2 cycles each.
- Read/write collision: a read whose AR handshake falls on the same edge as a write commit to the same register returns the pre-write value. A later read returns the new value.
- Channels are fully independent. Backpressure on B never stalls R, and backpressure on R never stalls B.
- AXI rule: no valid output depends combinationally on any input valid or ready.

Test Plan:
- Sequential write/read: write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to offsets 0x0, 0x4, 0x8, 0xC, each with wstrb=F, then read each back -> every bresp and rresp = 00; readback matches; regs_out reg k equals the k-th value; reg_wr_pulse fires once per write with reg_wr_index = 0..3.
- AW/W ordering: W with 0x12345678 three cycles before AW at 0x4, then AW three cycles before W at 0x8 -> bvalid is 1 exactly one cycle after the second handshake in each case; both values read back correctly.
- Byte strobes: reg0=0xFFFFFFFF, then write 0x00AA00BB with wstrb=0101 -> reg0 reads 0xFFAAFFBB; a write with wstrb=0000 -> bresp OKAY, no pulse, value unchanged.
- Out-of-range with backpressure: write to 0x10 and read 0x10 with bready=rready=0 for 5 cycles -> bresp=10 and rresp=10; rdata=0; bvalid and rvalid hold steady; no register change; arready and awready stay 0 until the respective handshake.
- Collision: reg1=0x11111111; write 0x22222222 to 0x4 with the commit edge equal to the AR handshake edge of a read of 0x4 -> that read returns 0x11111111; the next read returns 0x22222222.
- Reset mid-operation: assert aresetn=0 while bvalid=1 and an AR is pending -> all outputs are 0 asynchronously; after release, reg0..reg3 read 0 and a fresh write/read pair completes normally.
